// File: rtl/cf_minibus_pkg.sv
// Shared types, defaults and helpers for the Minibus-to-CompactFlash bridge.
package cf_minibus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] CF_ID_PRESENT = 8'hE5;
    localparam logic [7:0] CF_ID_ABSENT  = 8'hAD;

    localparam int STAT_PRESENT_BIT = 0;
    localparam int STAT_TIMEOUT_BIT = 1;
    localparam int STAT_BUSY_BIT    = 2;

    localparam int REG_SPACE_BIT = 13;
    localparam int CF_REG_BIT    = 12;

    // Width of a down-counter that must hold max_val; never narrower than 1 bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [7:0] status_byte(input logic busy,
                                               input logic tmo,
                                               input logic present);
        logic [7:0] s;
        s                   = 8'h00;
        s[STAT_BUSY_BIT]    = busy;
        s[STAT_TIMEOUT_BIT] = tmo;
        s[STAT_PRESENT_BIT] = present;
        return s;
    endfunction

endpackage

// File: rtl/cf_card_detect.sv
// Card detect synchroniser and debouncer, plus the stretched card reset
// that follows controller reset release and every card insertion.
module cf_card_detect
    import cf_minibus_pkg::*;
#(
    parameter int CD_DEB      = 16,
    parameter int RST_STRETCH = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cf_cd,
    output logic       card_present,
    output logic       cf_reset
);

    localparam int DEB_W = cnt_width(CD_DEB);
    localparam int STR_W = cnt_width(RST_STRETCH);
    localparam logic [DEB_W-1:0] DEB_LOAD = DEB_W'(CD_DEB - 1);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(RST_STRETCH);

    logic [1:0]       cd_meta;
    logic [1:0]       cd_sync;
    logic             raw_present;
    logic             deb_done;
    logic             insert;
    logic [DEB_W-1:0] deb_cnt;
    logic [STR_W-1:0] str_cnt;
    logic [STR_W-1:0] str_next;

    assign raw_present = (cd_sync == 2'b00);
    assign deb_done    = (raw_present != card_present) && (deb_cnt == '0);
    assign insert      = deb_done && raw_present;

    always_comb begin
        str_next = str_cnt;
        if (insert)
            str_next = STR_LOAD;
        else if (str_cnt != '0)
            str_next = str_cnt - STR_W'(1);
    end

    // Synchroniser resets to "absent" so the debouncer starts out agreeing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cd_meta      <= 2'b11;
            cd_sync      <= 2'b11;
            card_present <= 1'b0;
            deb_cnt      <= DEB_LOAD;
            str_cnt      <= STR_LOAD;
            cf_reset     <= 1'b1;
        end else begin
            cd_meta <= cf_cd;
            cd_sync <= cd_meta;
            if ((raw_present == card_present) || deb_done)
                deb_cnt <= DEB_LOAD;
            else
                deb_cnt <= deb_cnt - DEB_W'(1);
            if (deb_done)
                card_present <= raw_present;
            str_cnt  <= str_next;
            cf_reset <= (str_next != '0);
        end
    end

endmodule

// File: rtl/cf_minibus_bridge.sv
// Minibus-to-CompactFlash bridge: timed CF strobe sequencer with WAIT
// timeout, host completion handshake and a small ID/status register space.
//
// state  | meaning
// IDLE   | waiting for cs low; decode register / absent / CF access
// SETUP  | cf_ce low, address settling before the strobe
// STROBE | cf_oe or cf_we low; minimum width then WAIT extension
// HOLD   | strobe released, cf_ce still low
// DONE   | ack high until the host releases cs
module cf_minibus_bridge
    import cf_minibus_pkg::*;
#(
    parameter int         DATA_W      = 8,
    parameter int         HADDR_W     = 20,
    parameter int         CF_ADDR_W   = 11,
    parameter int         SETUP_CYC   = 1,
    parameter int         STROBE_CYC  = 3,
    parameter int         HOLD_CYC    = 1,
    parameter int         WAIT_TMO    = 255,
    parameter int         CD_DEB      = 16,
    parameter int         RST_STRETCH = 64,
    parameter logic [7:0] ID_PRESENT  = CF_ID_PRESENT,
    parameter logic [7:0] ID_ABSENT   = CF_ID_ABSENT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [HADDR_W-1:0]   address,
    input  logic                 cs,
    input  logic                 rw_b,
    input  logic [DATA_W-1:0]    data_in,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_oe,
    output logic                 ack,
    output logic                 cf_ce,
    output logic                 cf_oe,
    output logic                 cf_we,
    output logic                 cf_reg,
    output logic                 cf_reset,
    output logic [CF_ADDR_W-1:0] cf_address,
    output logic [DATA_W-1:0]    cf_data_out,
    output logic                 cf_data_oe,
    input  logic [DATA_W-1:0]    cf_data_in,
    input  logic                 cf_wait,
    input  logic [1:0]           cf_cd,
    output logic                 card_present,
    output logic                 timeout_err
);

    localparam int PH_MAX = (SETUP_CYC > STROBE_CYC)
                          ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                          : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int PH_W = cnt_width(PH_MAX);
    localparam int WT_W = cnt_width(WAIT_TMO);

    localparam logic [PH_W-1:0] SETUP_LOAD  = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0] STROBE_LOAD = PH_W'(STROBE_CYC - 1);
    localparam logic [PH_W-1:0] HOLD_LOAD   = PH_W'(HOLD_CYC - 1);
    localparam logic [WT_W-1:0] WAIT_LOAD   = WT_W'(WAIT_TMO);

    state_t            state;
    logic [PH_W-1:0]   ph_cnt;
    logic [WT_W-1:0]   wt_cnt;
    logic              is_read;
    logic [1:0]        wait_sync;
    logic              wait_low;
    logic [7:0]        reg_byte;
    logic [DATA_W-1:0] reg_rdata;
    logic              unused_addr;

    // Only a few address bits are decoded; the rest are don't-care here.
    assign unused_addr = ^address;

    cf_card_detect #(
        .CD_DEB      (CD_DEB),
        .RST_STRETCH (RST_STRETCH)
    ) u_card_detect (
        .clk          (clk),
        .reset        (reset),
        .cf_cd        (cf_cd),
        .card_present (card_present),
        .cf_reset     (cf_reset)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_sync <= 2'b11;
        else
            wait_sync <= {wait_sync[0], cf_wait};
    end

    assign wait_low = ~wait_sync[1];

    always_comb begin
        reg_byte  = address[0] ? status_byte(1'b0, timeout_err, card_present)
                               : (card_present ? ID_PRESENT : ID_ABSENT);
        reg_rdata = '0;
        reg_rdata[7:0] = reg_byte;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ph_cnt      <= '0;
            wt_cnt      <= '0;
            is_read     <= 1'b0;
            ack         <= 1'b0;
            data_oe     <= 1'b0;
            data_out    <= '0;
            cf_ce       <= 1'b1;
            cf_oe       <= 1'b1;
            cf_we       <= 1'b1;
            cf_reg      <= 1'b0;
            cf_address  <= '0;
            cf_data_out <= '0;
            cf_data_oe  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!cs) begin
                        is_read <= rw_b;
                        if (address[REG_SPACE_BIT]) begin
                            if (rw_b) begin
                                data_out <= reg_rdata;
                                if (address[0])
                                    timeout_err <= 1'b0;
                            end
                            state <= ST_DONE;
                        end else if (!card_present || cf_reset) begin
                            data_out <= '1;
                            state    <= ST_DONE;
                        end else begin
                            cf_address  <= address[CF_ADDR_W-1:0];
                            cf_reg      <= address[CF_REG_BIT];
                            cf_data_out <= data_in;
                            cf_ce       <= 1'b0;
                            ph_cnt      <= SETUP_LOAD;
                            state       <= ST_SETUP;
                        end
                    end
                end

                ST_SETUP: begin
                    if (ph_cnt == '0) begin
                        if (is_read) begin
                            cf_oe <= 1'b0;
                        end else begin
                            cf_we      <= 1'b0;
                            cf_data_oe <= 1'b1;
                        end
                        ph_cnt <= STROBE_LOAD;
                        wt_cnt <= WAIT_LOAD;
                        state  <= ST_STROBE;
                    end else begin
                        ph_cnt <= ph_cnt - PH_W'(1);
                    end
                end

                // Minimum width first; WAIT is only honoured once it has elapsed.
                ST_STROBE: begin
                    if (ph_cnt != '0) begin
                        ph_cnt <= ph_cnt - PH_W'(1);
                    end else if (wait_low && (wt_cnt != '0)) begin
                        wt_cnt <= wt_cnt - WT_W'(1);
                    end else begin
                        if (wait_low) begin
                            timeout_err <= 1'b1;
                            if (is_read)
                                data_out <= '1;
                        end else if (is_read) begin
                            data_out <= cf_data_in;
                        end
                        cf_oe  <= 1'b1;
                        cf_we  <= 1'b1;
                        ph_cnt <= HOLD_LOAD;
                        state  <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (ph_cnt == '0) begin
                        cf_ce      <= 1'b1;
                        cf_data_oe <= 1'b0;
                        state      <= ST_DONE;
                    end else begin
                        ph_cnt <= ph_cnt - PH_W'(1);
                    end
                end

                // ack is guaranteed at least one cycle before cs release is honoured.
                ST_DONE: begin
                    if (!ack) begin
                        ack     <= 1'b1;
                        data_oe <= is_read;
                    end else if (cs) begin
                        ack     <= 1'b0;
                        data_oe <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
